// File: rtl/mem_access_unit.sv
// Load/store alignment unit: byte-lane placement, sign extension and two-beat
// splitting of accesses that straddle a memory word, behind a single-outstanding bus port.
module mem_access_unit #(
    parameter int WIDTH            = 32,
    parameter int AW               = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_write,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH/8-1:0] mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);
    localparam int NB  = WIDTH / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;
    state_t state_q, state_d;

    logic             write_q, signed_q, split_q, err_q;
    logic [1:0]       size_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] wdata_q, beat0_q, beat1_q, rdata_q;
    logic             req_err, req_split;
    logic [AW-1:0]    base_addr;
    logic [2*NB-1:0]  be_full;
    logic [2*WIDTH-1:0] wd_full;
    logic [WIDTH-1:0] load_data;

    // Little-endian assembly of up to two beats, then zero/sign extension.
    function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0] b0,
                                                     input logic [WIDTH-1:0] b1,
                                                     input logic [OFS-1:0]   off,
                                                     input logic [1:0]       size,
                                                     input logic             sgn);
        logic [WIDTH-1:0] raw;
        logic [WIDTH-1:0] res;
        int nbits;
        raw   = (b0 >> (8 * int'(off))) | (b1 << (8 * (NB - int'(off))));
        nbits = 8 << size;
        if (nbits > WIDTH) nbits = WIDTH;
        for (int i = 0; i < WIDTH; i++)
            res[i] = (i < nbits) ? raw[i] : (sgn & raw[nbits-1]);
        return res;
    endfunction

    always_comb begin
        req_err   = (req_size > 2'(OFS)) ||
                    (!ALLOW_MISALIGNED &&
                     ((req_addr[OFS-1:0] & OFS'((1 << req_size) - 1)) != '0));
        req_split = (int'(req_addr[OFS-1:0]) + (1 << req_size)) > NB;
    end

    // Both beats' lanes come from one double-width shift: low half is beat 0, high half beat 1.
    always_comb begin
        base_addr = {addr_q[AW-1:OFS], {OFS{1'b0}}};
        be_full   = (2*NB)'((1 << (1 << size_q)) - 1) << addr_q[OFS-1:0];
        wd_full   = {{WIDTH{1'b0}}, wdata_q} << (8 * int'(addr_q[OFS-1:0]));
        load_data = (write_q || err_q) ? '0 :
                    load_extend(beat0_q, beat1_q, addr_q[OFS-1:0], size_q, signed_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid)  state_d = req_err ? RESP : BEAT0;
            BEAT0: if (mem_ready)  state_d = !write_q ? WAIT0 : (split_q ? BEAT1 : RESP);
            WAIT0: if (mem_rvalid) state_d = split_q ? BEAT1 : RESP;
            BEAT1: if (mem_ready)  state_d = write_q ? RESP : WAIT1;
            WAIT1: if (mem_rvalid) state_d = RESP;
            RESP:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = (state_q == RESP) ? load_data : rdata_q;
        mem_valid  = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        if (state_q == BEAT0) begin
            mem_valid = 1'b1;
            mem_write = write_q;
            mem_addr  = base_addr;
            mem_be    = be_full[NB-1:0];
            mem_wdata = wd_full[WIDTH-1:0];
        end else if (state_q == BEAT1) begin
            mem_valid = 1'b1;
            mem_write = write_q;
            mem_addr  = base_addr + AW'(NB);
            mem_be    = be_full[2*NB-1:NB];
            mem_wdata = wd_full[2*WIDTH-1:WIDTH];
        end
    end

    // Request fields and captured beats only matter inside a transaction, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            split_q  <= req_split;
            err_q    <= req_err;
            beat1_q  <= '0;
        end
        if (state_q == WAIT0 && mem_rvalid) beat0_q <= mem_rdata;
        if (state_q == WAIT1 && mem_rvalid) beat1_q <= mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                rdata_q <= '0;
        else if (state_q == RESP) rdata_q <= load_data;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (WIDTH=32): a reactive memory model records beats,
// and each scenario task compares results against hand-computed values.
module tb_mem_access_unit;
    logic        clk;
    logic        reset;
    logic        req_valid, req_valid2, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready, resp_valid, resp_err, mem_valid, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        req_ready2, resp_valid2, resp_err2, mem_valid2, mem_write2;
    logic [31:0] resp_rdata2, mem_addr2, mem_wdata2;
    logic [3:0]  mem_be2;

    int n_checks = 0;
    int n_fail = 0;

    int          nb = 0;
    logic [31:0] b_addr [64];
    logic [3:0]  b_be   [64];
    logic [31:0] b_wd   [64];
    logic        b_wr   [64];
    logic [31:0] rdtab  [64];
    int          stall_idx = -1;
    int          stall_cycles = 0;
    logic        stable_err = 1'b0;

    mem_access_unit #(.WIDTH(32), .AW(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.WIDTH(32), .AW(32), .ALLOW_MISALIGNED(1'b0)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid2),
        .resp_rdata(resp_rdata2), .resp_err(resp_err2), .mem_valid(mem_valid2),
        .mem_ready(mem_ready), .mem_write(mem_write2), .mem_addr(mem_addr2),
        .mem_be(mem_be2), .mem_wdata(mem_wdata2), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: accepts a beat on the first cycle it is offered (unless stalled), read data one cycle later.
    initial begin : mem_model
        int          stalled;
        logic        rd_pend;
        int          rd_idx;
        logic        snap;
        logic [31:0] s_addr, s_wd;
        logic [3:0]  s_be;
        stalled = 0; rd_pend = 1'b0; rd_idx = 0; snap = 1'b0;
        s_addr = '0; s_wd = '0; s_be = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (rd_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdtab[rd_idx];
                rd_pend    = 1'b0;
            end
            mem_ready = 1'b0;
            if (mem_valid && !reset) begin
                if (nb == stall_idx && stalled < stall_cycles) begin
                    if (!snap) begin
                        snap = 1'b1; s_addr = mem_addr; s_be = mem_be; s_wd = mem_wdata;
                    end else if (mem_addr !== s_addr || mem_be !== s_be || mem_wdata !== s_wd) begin
                        stable_err = 1'b1;
                    end
                    stalled++;
                end else begin
                    if (snap && (mem_addr !== s_addr || mem_be !== s_be || mem_wdata !== s_wd))
                        stable_err = 1'b1;
                    b_addr[nb] = mem_addr; b_be[nb] = mem_be; b_wd[nb] = mem_wdata; b_wr[nb] = mem_write;
                    if (!mem_write) begin rd_pend = 1'b1; rd_idx = nb; end
                    nb++;
                    mem_ready = 1'b1;
                    snap = 1'b0;
                    stalled = 0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic to2, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        if (to2) req_valid2 = 1'b1;
        else     req_valid  = 1'b1;
        tick;
        req_valid = 1'b0; req_valid2 = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
        req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) tick;
        n_checks++; if ({req_ready, resp_valid, resp_err, mem_valid, mem_write} !== 5'b10000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready, resp_valid, resp_err, mem_valid, mem_write}); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        n_checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin n_fail++; $display("FAIL reset_mem: got %h %h %h want 0", mem_addr, mem_wdata, mem_be); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_load_word;
        int base, lat;
        base = nb; rdtab[base] = 32'hDEADBEEF;
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        wait_resp(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ldw_latency: got %0d want 3", lat); end
        n_checks++; if (resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin n_fail++; $display("FAIL ldw_data: got %h err %b want deadbeef err 0", resp_rdata, resp_err); end
        n_checks++; if (nb - base !== 1 || b_addr[base] !== 32'h100 || b_be[base] !== 4'hF || b_wr[base] !== 1'b0) begin n_fail++; $display("FAIL ldw_beat: got n=%0d addr %h be %h wr %b want 1 100 f 0", nb - base, b_addr[base], b_be[base], b_wr[base]); end
        tick;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ldw_after: got v %b rdy %b rdata %h want 0 1 deadbeef", resp_valid, req_ready, resp_rdata); end
    endtask

    task automatic test_load_byte;
        int base, lat;
        logic [31:0] exp;
        for (int sg = 0; sg < 2; sg++) begin
            base = nb; rdtab[base] = 32'h80FF0000;
            exp = (sg == 1) ? 32'hFFFFFF80 : 32'h00000080;
            issue(1'b0, 1'b0, 2'd0, sg[0], 32'h103, 32'h0);
            wait_resp(lat);
            n_checks++; if (resp_rdata !== exp || lat !== 3) begin n_fail++; $display("FAIL ldb_data_s%0d: got %h lat %0d want %h lat 3", sg, resp_rdata, lat, exp); end
            n_checks++; if (b_addr[base] !== 32'h100 || b_be[base] !== 4'b1000) begin n_fail++; $display("FAIL ldb_beat_s%0d: got %h be %b want 100 1000", sg, b_addr[base], b_be[base]); end
            tick;
        end
    endtask

    task automatic test_store_half;
        int base, lat;
        base = nb;
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234);
        wait_resp(lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sth_latency: got %0d want 2", lat); end
        n_checks++; if (nb - base !== 1 || b_addr[base] !== 32'h100 || b_be[base] !== 4'b1100 || b_wd[base] !== 32'h12340000 || b_wr[base] !== 1'b1) begin n_fail++; $display("FAIL sth_beat: got n=%0d %h be %b wd %h wr %b want 1 100 1100 12340000 1", nb - base, b_addr[base], b_be[base], b_wd[base], b_wr[base]); end
        n_checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL sth_resp: got %h err %b want 0 0", resp_rdata, resp_err); end
        tick;
    endtask

    task automatic test_split_load;
        int base, lat;
        base = nb; rdtab[base] = 32'hAABB0000; rdtab[base+1] = 32'h0000CCDD;
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0);
        wait_resp(lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL spl_latency: got %0d want 5", lat); end
        n_checks++; if (resp_rdata !== 32'hCCDDAABB) begin n_fail++; $display("FAIL spl_data: got %h want ccddaabb", resp_rdata); end
        n_checks++; if (b_addr[base] !== 32'h0FC || b_be[base] !== 4'b1100) begin n_fail++; $display("FAIL spl_beat0: got %h be %b want 0fc 1100", b_addr[base], b_be[base]); end
        n_checks++; if (b_addr[base+1] !== 32'h100 || b_be[base+1] !== 4'b0011) begin n_fail++; $display("FAIL spl_beat1: got %h be %b want 100 0011", b_addr[base+1], b_be[base+1]); end
        tick;
    endtask

    task automatic test_split_store;
        int base, lat;
        base = nb; stall_idx = base; stall_cycles = 3;
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h103, 32'h11223344);
        wait_resp(lat);
        stall_idx = -1;
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL sps_latency: got %0d want 6", lat); end
        n_checks++; if (b_addr[base] !== 32'h100 || b_be[base] !== 4'b1000 || b_wd[base] !== 32'h44000000) begin n_fail++; $display("FAIL sps_beat0: got %h be %b wd %h want 100 1000 44000000", b_addr[base], b_be[base], b_wd[base]); end
        n_checks++; if (b_addr[base+1] !== 32'h104 || b_be[base+1] !== 4'b0111 || b_wd[base+1] !== 32'h00112233) begin n_fail++; $display("FAIL sps_beat1: got %h be %b wd %h want 104 0111 00112233", b_addr[base+1], b_be[base+1], b_wd[base+1]); end
        n_checks++; if (stable_err !== 1'b0) begin n_fail++; $display("FAIL sps_stable: got %b want 0", stable_err); end
        tick;
    endtask

    task automatic test_error_size;
        int base, lat;
        base = nb;
        issue(1'b0, 1'b0, 2'd3, 1'b1, 32'h100, 32'h0);
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL errsz_memvalid: got %b want 0", mem_valid); end
        wait_resp(lat);
        n_checks++; if (lat !== 1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL errsz_resp: got lat %0d err %b rdata %h want 1 1 0", lat, resp_err, resp_rdata); end
        tick;
        n_checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || nb !== base) begin n_fail++; $display("FAIL errsz_after: got v %b err %b beats %0d want 0 0 0", resp_valid, resp_err, nb - base); end
    endtask

    task automatic test_misaligned_reject;
        logic mv_seen;
        mv_seen = mem_valid2;
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
        mv_seen = mv_seen | mem_valid2;
        n_checks++; if (resp_valid2 !== 1'b1 || resp_err2 !== 1'b1 || resp_rdata2 !== 32'h0) begin n_fail++; $display("FAIL mis_resp: got v %b err %b rdata %h want 1 1 0", resp_valid2, resp_err2, resp_rdata2); end
        n_checks++; if ({mem_write2, mem_be2, mem_addr2, mem_wdata2} !== 69'h0) begin n_fail++; $display("FAIL mis_membus: got %b %h %h %h want 0", mem_write2, mem_be2, mem_addr2, mem_wdata2); end
        tick;
        mv_seen = mv_seen | mem_valid2;
        tick;
        mv_seen = mv_seen | mem_valid2;
        n_checks++; if (mv_seen !== 1'b0 || resp_valid2 !== 1'b0 || req_ready2 !== 1'b1) begin n_fail++; $display("FAIL mis_nobeat: got mv %b v %b rdy %b want 0 0 1", mv_seen, resp_valid2, req_ready2); end
    endtask

    task automatic test_back_to_back;
        int base, lat;
        base = nb; rdtab[base] = 32'h01020304; rdtab[base+1] = 32'h0A0B0C0D;
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", req_ready); end
        wait_resp(lat);
        n_checks++; if (req_ready !== 1'b0 || resp_rdata !== 32'h01020304) begin n_fail++; $display("FAIL b2b_first: got rdy %b rdata %h want 0 01020304", req_ready, resp_rdata); end
        tick;
        n_checks++; if (req_ready !== 1'b1 || resp_rdata !== 32'h01020304) begin n_fail++; $display("FAIL b2b_ready: got rdy %b rdata %h want 1 01020304", req_ready, resp_rdata); end
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h204, 32'h0);
        wait_resp(lat);
        n_checks++; if (lat !== 3 || resp_rdata !== 32'h0A0B0C0D || b_addr[base+1] !== 32'h204) begin n_fail++; $display("FAIL b2b_second: got lat %0d rdata %h addr %h want 3 0a0b0c0d 204", lat, resp_rdata, b_addr[base+1]); end
        tick;
    endtask

    task automatic test_reset_wait1;
        int base;
        logic rv_seen;
        base = nb; rdtab[base] = 32'h11111111; rdtab[base+1] = 32'h22222222;
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0);
        repeat (3) tick;
        n_checks++; if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || nb - base !== 2) begin n_fail++; $display("FAIL rst_wait1_pre: got mv %b v %b beats %0d want 0 0 2", mem_valid, resp_valid, nb - base); end
        reset = 1'b1;
        #1;
        n_checks++; if ({req_ready, resp_valid, resp_err, mem_valid, mem_write} !== 5'b10000) begin n_fail++; $display("FAIL rst_wait1_ctrl: got %b want 10000", {req_ready, resp_valid, resp_err, mem_valid, mem_write}); end
        n_checks++; if (resp_rdata !== 32'h0 || {mem_addr, mem_wdata, mem_be} !== 68'h0) begin n_fail++; $display("FAIL rst_wait1_data: got rdata %h mem %h %h %h want 0", resp_rdata, mem_addr, mem_wdata, mem_be); end
        tick;
        reset = 1'b0;
        rv_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            rv_seen = rv_seen | resp_valid;
        end
        n_checks++; if (rv_seen !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_wait1_after: got v %b rdy %b rdata %h want 0 1 0", rv_seen, req_ready, resp_rdata); end
    endtask

    initial begin
        test_reset;
        test_load_word;
        test_load_byte;
        test_store_half;
        test_split_load;
        test_split_store;
        test_error_size;
        test_misaligned_reject;
        test_back_to_back;
        test_reset_wait1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store alignment unit placed between the multicycle core's address/result path and the memory port. It replaces single-beat byte-lane selection with full support for byte, halfword, word and (at WIDTH=64) doubleword accesses: signed or unsigned loads, byte-enabled stores, and misaligned accesses that cross a memory-word boundary, which it splits into two memory beats. It presents a valid/ready request channel to the core and a single-outstanding valid/ready memory channel to the bus.

## Interface
- WIDTH, 32: memory/data width in bits; 32 or 64. NB = WIDTH/8, OFS = log2(NB).
- AW, 32: address width.
- ALLOW_MISALIGNED, 1: 1 = split boundary-crossing accesses; 0 = reject any address not a multiple of access size.

- clk  in  1  clock. One clock.
- reset  in  1  reset; asynchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit idle, request accepted when req_valid high.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  log2 bytes: 0 byte, 1 half, 2 word, 3 dword.
- req_signed  in  1  sign-extend load result.
- req_addr  in  AW  byte address.
- req_wdata  in  WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WIDTH  extended load data; 0 for stores/errors.
- resp_err  out  1  illegal size or disallowed misalignment; qualified by resp_valid.
- mem_valid  out  1  memory beat request.
- mem_ready  in  1  memory accepts beat.
- mem_write  out  1  beat is a write.
- mem_addr  out  AW  NB-aligned address (low OFS bits 0).
- mem_be  out  NB  byte enables.
- mem_wdata  out  WIDTH  lane-shifted store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  WIDTH  read data.

## Operation
- States: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid: latch write, size, signed, addr, wdata; bytes = 1<<size, off = addr[OFS-1:0].
- Error check at acceptance: size > OFS, or ALLOW_MISALIGNED=0 and addr mod bytes != 0 -> RESP with resp_err=1, no memory beat.
- split = (off + bytes > NB). Otherwise single beat (misaligned within one word needs no split).
- BEAT0: mem_valid=1, mem_addr = addr with low OFS bits cleared, mem_be = ((1<<bytes)-1) << off truncated to NB, mem_wdata = wdata << 8*off. Hold all mem_* stable until mem_ready. On mem_ready: read -> WAIT0; write -> BEAT1 if split else RESP.
- WAIT0: on mem_rvalid capture lanes; -> BEAT1 if split else RESP.
- BEAT1: mem_addr = beat0 address + NB (wraps modulo 2^AW), mem_be = bytes above the beat0 lanes placed from lane 0, mem_wdata = wdata >> 8*(NB-off). On mem_ready: read -> WAIT1, write -> RESP.
- WAIT1: on mem_rvalid capture lanes -> RESP.
- Load assembly, little-endian: data = (beat0 >> 8*off) | (beat1 << 8*(NB-off)), truncated to 8*bytes, then zero- or sign-extended (bit 8*bytes-1) to WIDTH. Size = WIDTH ignores req_signed.
- RESP: resp_valid=1 for exactly one cycle, -> IDLE. resp_rdata held until next resp_valid.
- mem_rvalid outside WAIT0/WAIT1 is ignored. mem_rvalid never arrives in the same cycle as its mem_ready acceptance.

## Timing
- Reset (asynchronous): state IDLE; req_ready=1; resp_valid, resp_err, resp_rdata, mem_valid, mem_write, mem_addr, mem_be, mem_wdata = 0.
- Reset mid-transaction abandons it: no resp_valid, and a pending mem_rvalid is dropped.
- Latency from acceptance cycle T, with mem_ready=1 on first assertion and rvalid one cycle later: aligned read, resp_valid at T+3; split read, T+5; aligned write, T+2; split write, T+3; error, T+1.
- Each cycle of mem_ready=0 adds one cycle. Each cycle of rvalid delay adds one cycle.
- No new request is accepted before the RESP cycle has passed. Back-to-back: req_ready=1 in the cycle after RESP.

## Test plan
- WIDTH=32, load word at 0x100, mem_rdata=0xDEADBEEF: mem_addr 0x100, be 4'hF; resp_rdata 0xDEADBEEF at T+3, resp_err=0.
- Load byte at 0x103, mem_rdata=0x80FF0000: be 4'b1000; signed gives 0xFFFFFF80, unsigned gives 0x00000080.
- Store half at 0x102, wdata 0x1234: mem_wdata 0x12340000, be 4'b1100; resp_valid at T+2.
- Split load word at 0x0FE: beat0 at 0x0FC, be 1100, returns 0xAABB0000; beat1 at 0x100, be 0011, returns 0x0000CCDD; resp_rdata 0xCCDDAABB at T+5.
- Split store word 0x11223344 at 0x103, mem_ready low 3 cycles on beat0: beat0 0x100, be 1000, wdata 0x44000000, held stable; beat1 0x104, be 0111, wdata 0x00112233.
- Error and reset cases:
  - ALLOW_MISALIGNED=0, word at 0x102: resp_err=1 at T+1, mem_valid never asserted.
  - size=3 at WIDTH=32: resp_err=1.
  - reset asserted in WAIT1: all outputs immediately at reset values, no resp_valid.
